// File: rtl/axil_sram_ysyx_24100029_pkg.sv
// ---------------------------------------------------------------------------
// axil_pkg_ysyx_24100029
// Shared types and constants for the AXI4-Lite SRAM slave.
//   RESP_OKAY / RESP_DECERR : AXI response codes driven on rresp / bresp
//   rd_state_t              : read engine states  (AR accept, wait, R response)
//   wr_state_t              : write engine states (AW/W collect, wait, B response)
// ---------------------------------------------------------------------------
package axil_pkg_ysyx_24100029;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WAIT,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axil_sram_ysyx_24100029_if.sv
// ---------------------------------------------------------------------------
// axil_sram_ysyx_24100029_if
// AXI4-Lite bus bundle between a master (IFU / MEM stage, or a testbench)
// and the SRAM slave. Clock and reset are kept outside as plain ports.
//   AR/R : araddr, arvalid, arready, rdata, rresp, rvalid, rready
//   AW/W : awaddr, awvalid, awready, wdata, wstrb, wvalid, wready
//   B    : bresp, bvalid, bready
// Modports: master drives requests and response-ready, slave the rest.
// ---------------------------------------------------------------------------
interface axil_sram_ysyx_24100029_if;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid,
        input  awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid,
        output awready, wready, bresp, bvalid
    );

endinterface

// File: rtl/axil_sram_ysyx_24100029_lfsr8.sv
// ---------------------------------------------------------------------------
// lfsr8_ysyx_24100029
// 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1, advancing every
// clock. Supplies pseudo-random response delays to the SRAM slave.
// Only compiled when AXIL_SRAM_RAND_DELAY_EN is defined; the fixed-latency
// build has no use for it.
//   clk : clock
//   rst : asynchronous active-high reset, loads SEED (must be nonzero)
//   q   : current LFSR state
// ---------------------------------------------------------------------------
`ifdef AXIL_SRAM_RAND_DELAY_EN
module lfsr8_ysyx_24100029 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= SEED;
        else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    end

endmodule
`endif

// File: rtl/axil_sram_ysyx_24100029.sv
// ---------------------------------------------------------------------------
// axil_sram_ysyx_24100029
// AXI4-Lite slave SRAM serving instruction fetches and data loads/stores.
// Word-addressed array with byte-strobed writes; independent read and write
// engines, each with one transaction in flight and a programmable delay
// between request accept and response valid.
//   clk : clock, all logic on posedge
//   rst : asynchronous active-high reset (array contents are not reset)
//   bus : AXI4-Lite slave modport (AR/R, AW/W/B channels)
// Parameters: ADDR_BASE (byte address of word 0), DEPTH_WORDS (power of two),
//   LATENCY (fixed wait cycles 0..15), LFSR_SEED (random-delay seed).
// Build option: define AXIL_SRAM_RAND_DELAY_EN to draw each delay from an
//   LFSR (0..7 cycles) instead of LATENCY.
// ---------------------------------------------------------------------------
module axil_sram_ysyx_24100029
    import axil_pkg_ysyx_24100029::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input logic                      clk,
    input logic                      rst,
    axil_sram_ysyx_24100029_if.slave bus
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = {1'b0, ADDR_BASE} + 33'(4 * DEPTH_WORDS);

    // 33-bit compare so a window ending at 2^32 cannot wrap around.
    function automatic logic addr_ok(input logic [31:0] a);
        return ({1'b0, a} >= {1'b0, ADDR_BASE}) && ({1'b0, a} < ADDR_END);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [31:0] a);
        return IDX_W'((a - ADDR_BASE) >> 2);
    endfunction

    // ---------------- response delay source ----------------
    logic [3:0] delay;
`ifdef AXIL_SRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;
    lfsr8_ysyx_24100029 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (lfsr_q)
    );
    assign delay = {1'b0, lfsr_q[2:0]};
`else
    assign delay = 4'(LATENCY);
`endif

    logic [31:0] mem [DEPTH_WORDS];

    // ---------------- read engine ----------------
    rd_state_t        rd_state, rd_state_n;
    logic [3:0]       rd_cnt, rd_cnt_n;
    logic [IDX_W-1:0] rd_idx, rd_idx_n;
    logic             rd_ok, rd_ok_n;
    logic [31:0]      rdata_q, rdata_n;
    logic [1:0]       rresp_q, rresp_n;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the combinational block below uses blocking ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= R_IDLE;
            rd_cnt   <= '0;
            rd_idx   <= '0;
            rd_ok    <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rd_state <= rd_state_n;
            rd_cnt   <= rd_cnt_n;
            rd_idx   <= rd_idx_n;
            rd_ok    <= rd_ok_n;
            rdata_q  <= rdata_n;
            rresp_q  <= rresp_n;
        end
    end

    // NOTE: every output of this block gets a hold default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        rd_state_n = rd_state;
        rd_cnt_n   = rd_cnt;
        rd_idx_n   = rd_idx;
        rd_ok_n    = rd_ok;
        rdata_n    = rdata_q;
        rresp_n    = rresp_q;
        unique case (rd_state)
            R_IDLE: begin
                if (bus.arvalid) begin
                    rd_idx_n   = addr_idx(bus.araddr);
                    rd_ok_n    = addr_ok(bus.araddr);
                    rd_cnt_n   = delay;
                    rd_state_n = R_WAIT;
                end
            end
            R_WAIT: begin
                if (rd_cnt != 4'd0) begin
                    rd_cnt_n = rd_cnt - 4'd1;
                end else begin
                    // Sampled before this edge's write commit: a same-cycle
                    // write to this word is not yet visible.
                    rdata_n    = rd_ok ? mem[rd_idx] : '0;
                    rresp_n    = rd_ok ? RESP_OKAY : RESP_DECERR;
                    rd_state_n = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.rready) rd_state_n = R_IDLE;
            end
            default: rd_state_n = R_IDLE;
        endcase
    end

    assign bus.arready = (rd_state == R_IDLE) && !rst;
    assign bus.rvalid  = (rd_state == R_RESP);
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    // ---------------- write engine ----------------
    wr_state_t        wr_state, wr_state_n;
    logic [3:0]       wr_cnt, wr_cnt_n;
    logic             aw_held, aw_held_n;
    logic             w_held, w_held_n;
    logic [IDX_W-1:0] wr_idx, wr_idx_n;
    logic             wr_ok, wr_ok_n;
    logic [31:0]      wr_data, wr_data_n;
    logic [3:0]       wr_strb, wr_strb_n;
    logic [1:0]       bresp_q, bresp_n;
    logic             mem_we;
    logic             aw_fire, w_fire;

    assign bus.awready = (wr_state == W_IDLE) && !aw_held && !rst;
    assign bus.wready  = (wr_state == W_IDLE) && !w_held && !rst;
    assign bus.bvalid  = (wr_state == W_RESP);
    assign bus.bresp   = bresp_q;
    assign aw_fire     = bus.awvalid && bus.awready;
    assign w_fire      = bus.wvalid && bus.wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_cnt   <= '0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            wr_idx   <= '0;
            wr_ok    <= 1'b0;
            wr_data  <= '0;
            wr_strb  <= '0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wr_state <= wr_state_n;
            wr_cnt   <= wr_cnt_n;
            aw_held  <= aw_held_n;
            w_held   <= w_held_n;
            wr_idx   <= wr_idx_n;
            wr_ok    <= wr_ok_n;
            wr_data  <= wr_data_n;
            wr_strb  <= wr_strb_n;
            bresp_q  <= bresp_n;
        end
    end

    always_comb begin
        wr_state_n = wr_state;
        wr_cnt_n   = wr_cnt;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        wr_idx_n   = wr_idx;
        wr_ok_n    = wr_ok;
        wr_data_n  = wr_data;
        wr_strb_n  = wr_strb;
        bresp_n    = bresp_q;
        mem_we     = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_n = 1'b1;
                    wr_idx_n  = addr_idx(bus.awaddr);
                    wr_ok_n   = addr_ok(bus.awaddr);
                end
                if (w_fire) begin
                    w_held_n  = 1'b1;
                    wr_data_n = bus.wdata;
                    wr_strb_n = bus.wstrb;
                end
                // Leave only once both halves sit in registers.
                if (aw_held && w_held) begin
                    wr_cnt_n   = delay;
                    wr_state_n = W_WAIT;
                end
            end
            W_WAIT: begin
                if (wr_cnt != 4'd0) begin
                    wr_cnt_n = wr_cnt - 4'd1;
                end else begin
                    mem_we     = wr_ok;
                    bresp_n    = wr_ok ? RESP_OKAY : RESP_DECERR;
                    wr_state_n = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    wr_state_n = W_IDLE;
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                end
            end
            default: wr_state_n = W_IDLE;
        endcase
    end

    // NOTE: the array has no reset branch; clearing thousands of words is not
    // needed and would block mapping onto a RAM macro.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axil_sram_ysyx_24100029.sv
// ---------------------------------------------------------------------------
// tb_axil_sram_ysyx_24100029
// Self-checking bench for the AXI4-Lite SRAM slave (default parameters,
// LATENCY = 1). A table of read/write vectors with hand-computed results,
// followed by hand-written sequences for reset state, response back-pressure,
// reset during a pending write and a same-cycle read/write collision.
// ---------------------------------------------------------------------------
module tb_axil_sram_ysyx_24100029;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    axil_sram_ysyx_24100029_if bus ();

    axil_sram_ysyx_24100029 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_read;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          w_lead;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Latency check; with random delays the window is fixed latency -1..+6.
    task automatic check_lat(input string name, input int act, input int exp);
        n_checks++;
`ifdef AXIL_SRAM_RAND_DELAY_EN
        if (act < exp - 1 || act > exp + 6) begin
`else
        if (act != exp) begin
`endif
            n_errors++;
            $display("FAIL %s: got %0d cycles expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the cycle count from the last AW/W handshake edge to bvalid.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead,
                            output logic [1:0] resp, output int lat);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        bus.wdata  = data;
        bus.wstrb  = strb;
        bus.wvalid = 1'b1;
        bus.awaddr = addr;
        bus.awvalid = (w_lead == 0);
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            tick();
            cyc++;
            if (aw_hs) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.wvalid = 1'b0; end
            if (!aw_done && !bus.awvalid && cyc >= w_lead) bus.awvalid = 1'b1;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        lat = 0;
        while (!bus.bvalid && lat < 50) begin
            tick();
            lat++;
        end
        resp = bus.bresp;
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
    endtask

    // Returns the cycle count from the AR handshake edge to rvalid.
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int lat);
        int cyc = 0;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        while (!bus.arready && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        bus.arvalid = 1'b0;
        lat = 0;
        while (!bus.rvalid && lat < 50) begin
            tick();
            lat++;
        end
        data = bus.rdata;
        resp = bus.rresp;
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
    endtask

    task automatic wait_sig_r(input string name);
        int cyc = 0;
        while (!bus.rvalid && cyc < 50) begin tick(); cyc++; end
        check(name, 32'(bus.rvalid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rs;
        int          lat;

        //               rd addr           data          strb   lead exp_data      resp   lat
        vecs[0]  = '{1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         2'b00, 3};
        vecs[1]  = '{1'b1, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 2'b00, 2};
        vecs[2]  = '{1'b0, 32'h8000_0010, 32'h0000_AB00, 4'h2, 2, 32'h0,         2'b00, 3};
        vecs[3]  = '{1'b1, 32'h8000_0010, 32'h0,         4'h0, 0, 32'hDEAD_ABEF, 2'b00, 2};
        vecs[4]  = '{1'b1, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, 32'h0,         2'b11, 2};
        vecs[5]  = '{1'b1, 32'h8000_4000, 32'h0,         4'h0, 0, 32'h0,         2'b11, 2};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h1234_5678, 4'hF, 0, 32'h0,         2'b00, 3};
        vecs[7]  = '{1'b0, 32'h7FFF_FFFC, 32'hAAAA_AAAA, 4'hF, 0, 32'h0,         2'b11, 3};
        vecs[8]  = '{1'b0, 32'h8000_4000, 32'h5555_5555, 4'hF, 0, 32'h0,         2'b11, 3};
        vecs[9]  = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h1234_5678, 2'b00, 2};
        vecs[10] = '{1'b0, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 0, 32'h0,         2'b00, 3};
        vecs[11] = '{1'b1, 32'h8000_3FFF, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 2'b00, 2};
        vecs[12] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 0, 32'h0,         2'b00, 3};
        vecs[13] = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h1234_5678, 2'b00, 2};
        vecs[14] = '{1'b0, 32'h8000_0002, 32'h9ABC_0000, 4'hC, 1, 32'h0,         2'b00, 3};
        vecs[15] = '{1'b1, 32'h8000_0000, 32'h0,         4'h0, 0, 32'h9ABC_5678, 2'b00, 2};

        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata  = '0;
        bus.wstrb  = '0; bus.wvalid  = 1'b0; bus.bready = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst arready", 32'(bus.arready), 32'd0);
        check("rst awready", 32'(bus.awready), 32'd0);
        check("rst wready",  32'(bus.wready),  32'd0);
        check("rst rvalid",  32'(bus.rvalid),  32'd0);
        check("rst bvalid",  32'(bus.bvalid),  32'd0);
        check("rst rdata",   bus.rdata,        32'd0);
        check("rst rresp",   32'(bus.rresp),   32'd0);
        check("rst bresp",   32'(bus.bresp),   32'd0);
        rst = 1'b0;
        #1;
        check("post-rst arready", 32'(bus.arready), 32'd1);
        check("post-rst awready", 32'(bus.awready), 32'd1);
        check("post-rst wready",  32'(bus.wready),  32'd1);
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_read) begin
                do_read(vecs[i].addr, rd, rs, lat);
                check($sformatf("v%0d rdata", i), rd, vecs[i].exp_data);
                check($sformatf("v%0d rresp", i), 32'(rs), 32'(vecs[i].exp_resp));
            end else begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].w_lead, rs, lat);
                check($sformatf("v%0d bresp", i), 32'(rs), 32'(vecs[i].exp_resp));
            end
            check_lat($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
            tick();
        end

        // ---------------- rready back-pressure ----------------
        bus.araddr  = 32'h8000_0010;
        bus.arvalid = 1'b1;
        tick();                              // AR accepted
        bus.araddr  = 32'h8000_0000;         // second request held pending
        wait_sig_r("bp rvalid rise");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp%0d rvalid", i),  32'(bus.rvalid),  32'd1);
            check($sformatf("bp%0d rdata", i),   bus.rdata,        32'hDEAD_ABEF);
            check($sformatf("bp%0d arready", i), 32'(bus.arready), 32'd0);
            tick();
        end
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        check("bp rvalid dropped", 32'(bus.rvalid),  32'd0);
        check("bp arready back",   32'(bus.arready), 32'd1);
        tick();                              // second AR accepted
        bus.arvalid = 1'b0;
        wait_sig_r("bp2 rvalid rise");
        check("bp2 rdata", bus.rdata, 32'h9ABC_5678);
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        tick();

        // ---------------- reset during W_WAIT ----------------
        do_write(32'h8000_0020, 32'h1111_1111, 4'hF, 0, rs, lat);
        check("rw pre bresp", 32'(rs), 32'd0);
        bus.awaddr = 32'h8000_0020; bus.awvalid = 1'b1;
        bus.wdata  = 32'h2222_2222; bus.wstrb   = 4'hF; bus.wvalid = 1'b1;
        tick();                              // AW and W accepted
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        tick();                              // now in W_WAIT
        rst = 1'b1;
        #2;
        check("rw bvalid in rst", 32'(bus.bvalid),  32'd0);
        check("rw awready in rst", 32'(bus.awready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rw%0d bvalid", i), 32'(bus.bvalid), 32'd0);
        end
        check("rw awready after", 32'(bus.awready), 32'd1);
        do_read(32'h8000_0020, rd, rs, lat);
        check("rw word kept", rd, 32'h1111_1111);
        tick();

        // ---------------- same-cycle read sample / write commit ----------------
        bus.awaddr = 32'h8000_0020; bus.awvalid = 1'b1;
        bus.wdata  = 32'h3333_3333; bus.wstrb   = 4'hF; bus.wvalid = 1'b1;
        tick();                              // write handshake
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.araddr  = 32'h8000_0020;
        bus.arvalid = 1'b1;
        tick();                              // read handshake one cycle later
        bus.arvalid = 1'b0;
        wait_sig_r("col rvalid rise");
`ifdef AXIL_SRAM_RAND_DELAY_EN
        check("col rdata either", 32'(bus.rdata == 32'h1111_1111 || bus.rdata == 32'h3333_3333), 32'd1);
`else
        check("col rdata pre-write", bus.rdata, 32'h1111_1111);
`endif
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        begin
            int cyc = 0;
            while (!bus.bvalid && cyc < 50) begin tick(); cyc++; end
        end
        check("col bvalid", 32'(bus.bvalid), 32'd1);
        check("col bresp",  32'(bus.bresp),  32'd0);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        do_read(32'h8000_0020, rd, rs, lat);
        check("col rdata post-write", rd, 32'h3333_3333);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
